// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: bus commands, access sizes,
// client identifiers and the per-tag ownership record.
package mem_bus_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int TAG_W    = 4;
    localparam int NUM_TAGS = 15;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic {
        ARB_ICACHE = 1'b0,
        ARB_DCACHE = 1'b1
    } ARB_CLIENT;

    typedef struct packed {
        logic      valid;
        ARB_CLIENT owner;
    } TAG_OWNER_ENTRY;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Records which client owns each outstanding load tag (1..15).
// A clear and a set to the same tag in one cycle leaves the entry set, so a
// tag recycled by memory in the cycle it returns goes to the new owner.
module mem_tag_owner_table
    import mem_bus_arbiter_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set_en_i,
    input  logic [TAG_W-1:0]     set_tag_i,
    input  ARB_CLIENT            set_owner_i,
    input  logic                 clr_en_i,
    input  logic [TAG_W-1:0]     clr_tag_i,
    input  logic [TAG_W-1:0]     lookup_tag_i,
    output TAG_OWNER_ENTRY       lookup_o
);

    TAG_OWNER_ENTRY table_q [1:NUM_TAGS];
    TAG_OWNER_ENTRY table_d [1:NUM_TAGS];

    // Next table contents: clear the returning tag first, then apply a new grant.
    always_comb begin
        table_d = table_q;
        if (clr_en_i && (clr_tag_i != '0)) begin
            table_d[clr_tag_i].valid = 1'b0;
        end
        if (set_en_i && (set_tag_i != '0)) begin
            table_d[set_tag_i].valid = 1'b1;
            table_d[set_tag_i].owner = set_owner_i;
        end
    end

    // Tag 0 is never stored, so it always looks up as unowned.
    always_comb begin
        lookup_o = '0;
        if (lookup_tag_i != '0) begin
            lookup_o = table_q[lookup_tag_i];
        end
    end

    // Table storage with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 1; i <= NUM_TAGS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the I-cache and D-cache miss paths onto the single memory port,
// tracks load-tag ownership and steers returning data to the owning client.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUT_I = 4,
    parameter int MAX_OUT_D = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           ic_command,
    input  logic [XLEN-1:0]      ic_addr,
    output logic [TAG_W-1:0]     ic_response,
    output logic                 ic_rd_valid,
    output logic [TAG_W-1:0]     ic_rd_tag,
    output logic [63:0]          ic_rd_data,
    input  logic [1:0]           dc_command,
    input  logic [XLEN-1:0]      dc_addr,
    input  logic [63:0]          dc_data,
    input  logic [1:0]           dc_size,
    output logic [TAG_W-1:0]     dc_response,
    output logic                 dc_rd_valid,
    output logic [TAG_W-1:0]     dc_rd_tag,
    output logic [63:0]          dc_rd_data,
    output logic [1:0]           proc2mem_command,
    output logic [XLEN-1:0]      proc2mem_addr,
    output logic [63:0]          proc2mem_data,
    output logic [1:0]           proc2mem_size,
    input  logic [TAG_W-1:0]     mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [TAG_W-1:0]     mem2proc_tag,
    output logic                 spurious_tag
);

    localparam logic [3:0] MAX_I = 4'(MAX_OUT_I);
    localparam logic [3:0] MAX_D = 4'(MAX_OUT_D);

    ARB_CLIENT      rr_last_q, rr_last_d;
    logic [3:0]     ic_cnt_q, ic_cnt_d;
    logic [3:0]     dc_cnt_q, dc_cnt_d;
    logic           spurious_q;
    logic           ic_rd_valid_q, dc_rd_valid_q;
    logic [TAG_W-1:0] ic_rd_tag_q, dc_rd_tag_q;
    logic [63:0]    ic_rd_data_q, dc_rd_data_q;

    logic           ic_elig, dc_elig, grant_ic, grant_dc;
    logic           accepted, win_load, set_en;
    ARB_CLIENT      winner;
    TAG_OWNER_ENTRY lookup;
    logic           ret_hit, ret_miss;
    logic           ic_inc, ic_dec, dc_inc, dc_dec;

    mem_tag_owner_table u_owner_table (
        .clock        (clock),
        .reset        (reset),
        .set_en_i     (set_en),
        .set_tag_i    (mem2proc_response),
        .set_owner_i  (winner),
        .clr_en_i     (ret_hit),
        .clr_tag_i    (mem2proc_tag),
        .lookup_tag_i (mem2proc_tag),
        .lookup_o     (lookup)
    );

    // Pick at most one client per cycle and drive its command to memory.
    always_comb begin
        ic_elig = (ic_command != BUS_NONE) &&
                  ((ic_command == BUS_STORE) || (ic_cnt_q < MAX_I));
        dc_elig = (dc_command != BUS_NONE) &&
                  ((dc_command == BUS_STORE) || (dc_cnt_q < MAX_D));
        grant_dc = reset && dc_elig && (!ic_elig || (rr_last_q == ARB_ICACHE));
        grant_ic = reset && ic_elig && !grant_dc;

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = '0;
        ic_response      = '0;
        dc_response      = '0;
        if (grant_dc) begin
            proc2mem_command = dc_command;
            proc2mem_addr    = dc_addr;
            proc2mem_data    = dc_data;
            proc2mem_size    = dc_size;
            dc_response      = mem2proc_response;
        end else if (grant_ic) begin
            proc2mem_command = ic_command;
            proc2mem_addr    = ic_addr;
            proc2mem_size    = DOUBLE;
            ic_response      = mem2proc_response;
        end

        accepted = (grant_dc || grant_ic) && (mem2proc_response != '0);
        winner   = grant_dc ? ARB_DCACHE : ARB_ICACHE;
        win_load = grant_dc ? (dc_command == BUS_LOAD) : (ic_command == BUS_LOAD);
        set_en   = accepted && win_load;
    end

    // Classify the returning tag and compute fairness/counter updates.
    always_comb begin
        ret_hit  = reset && (mem2proc_tag != '0) && lookup.valid;
        ret_miss = reset && (mem2proc_tag != '0) && !lookup.valid;

        rr_last_d = accepted ? winner : rr_last_q;

        ic_inc = set_en && (winner == ARB_ICACHE) && (ic_cnt_q != 4'hF);
        dc_inc = set_en && (winner == ARB_DCACHE) && (dc_cnt_q != 4'hF);
        ic_dec = ret_hit && (lookup.owner == ARB_ICACHE) && (ic_cnt_q != 4'h0);
        dc_dec = ret_hit && (lookup.owner == ARB_DCACHE) && (dc_cnt_q != 4'h0);

        ic_cnt_d = ic_cnt_q + 4'(ic_inc) - 4'(ic_dec);
        dc_cnt_d = dc_cnt_q + 4'(dc_inc) - 4'(dc_dec);
    end

    // Registered state and the one-cycle return path to each client.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_last_q     <= ARB_ICACHE;
            ic_cnt_q      <= '0;
            dc_cnt_q      <= '0;
            spurious_q    <= 1'b0;
            ic_rd_valid_q <= 1'b0;
            ic_rd_tag_q   <= '0;
            ic_rd_data_q  <= '0;
            dc_rd_valid_q <= 1'b0;
            dc_rd_tag_q   <= '0;
            dc_rd_data_q  <= '0;
        end else begin
            rr_last_q     <= rr_last_d;
            ic_cnt_q      <= ic_cnt_d;
            dc_cnt_q      <= dc_cnt_d;
            spurious_q    <= spurious_q | ret_miss;
            ic_rd_valid_q <= ret_hit && (lookup.owner == ARB_ICACHE);
            dc_rd_valid_q <= ret_hit && (lookup.owner == ARB_DCACHE);
            if (ret_hit && (lookup.owner == ARB_ICACHE)) begin
                ic_rd_tag_q  <= mem2proc_tag;
                ic_rd_data_q <= mem2proc_data;
            end
            if (ret_hit && (lookup.owner == ARB_DCACHE)) begin
                dc_rd_tag_q  <= mem2proc_tag;
                dc_rd_data_q <= mem2proc_data;
            end
        end
    end

    assign ic_rd_valid  = ic_rd_valid_q;
    assign ic_rd_tag    = ic_rd_tag_q;
    assign ic_rd_data   = ic_rd_data_q;
    assign dc_rd_valid  = dc_rd_valid_q;
    assign dc_rd_tag    = dc_rd_tag_q;
    assign dc_rd_data   = dc_rd_data_q;
    assign spurious_tag = spurious_q;

endmodule
